// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues word loads/stores to the data memory,
// stalls the upstream pipeline while an access is pending and produces a
// registered writeback (or an error pulse) for the MEM/WB stage.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ex_valid,
    input  logic        i_ex_mem_rd,
    input  logic        i_ex_mem_wr,
    input  logic [31:0] i_ex_addr,
    input  logic [31:0] i_ex_wdata,
    input  logic [4:0]  i_ex_rd,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_stall,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_err
);

    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    // Value the counter holds in the last BUSY cycle before it would reach TIMEOUT.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic {
        StIdle,
        StBusy
    } state_t;

    state_t            r_state, w_state_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic [31:0]       r_addr, w_addr_d;
    logic [31:0]       r_wdata, w_wdata_d;
    logic              r_we, w_we_d;
    logic [4:0]        r_rd, w_rd_d;
    logic              r_wb_valid, w_wb_valid_d;
    logic [4:0]        r_wb_rd, w_wb_rd_d;
    logic [31:0]       r_wb_data, w_wb_data_d;
    logic              r_err, w_err_d;
    logic              w_stall;

    logic w_is_mem;
    logic w_legal_mem;

    assign w_is_mem    = i_ex_mem_rd | i_ex_mem_wr;
    assign w_legal_mem = (i_ex_mem_rd ^ i_ex_mem_wr) && (i_ex_addr[1:0] == 2'b00);

    // Next-state, latch and writeback/error decode; defaults hold state, pulses low.
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_we_d       = r_we;
        w_rd_d       = r_rd;
        w_wb_valid_d = 1'b0;
        w_wb_rd_d    = r_wb_rd;
        w_wb_data_d  = r_wb_data;
        w_err_d      = 1'b0;
        w_stall      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_ex_valid) begin
                    if (!w_is_mem) begin
                        // Non-memory op: ALU result passes straight to writeback.
                        w_wb_valid_d = 1'b1;
                        w_wb_data_d  = i_ex_addr;
                        w_wb_rd_d    = i_ex_rd;
                    end else if (w_legal_mem) begin
                        w_state_d = StBusy;
                        w_cnt_d   = '0;
                        w_addr_d  = i_ex_addr;
                        w_wdata_d = i_ex_wdata;
                        w_we_d    = i_ex_mem_wr;
                        w_rd_d    = i_ex_rd;
                        w_stall   = 1'b1;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (i_dmem_ack) begin
                    // Ack wins over timeout; release stall so upstream advances now.
                    w_state_d = StIdle;
                    if (!r_we) begin
                        w_wb_valid_d = 1'b1;
                        w_wb_data_d  = i_dmem_rdata;
                        w_wb_rd_d    = r_rd;
                    end
                end else if (r_cnt == CntLast) begin
                    w_state_d = StIdle;
                    w_cnt_d   = r_cnt + 1'b1;
                    w_err_d   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_we       <= w_we_d;
            r_rd       <= w_rd_d;
            r_wb_valid <= w_wb_valid_d;
            r_wb_rd    <= w_wb_rd_d;
            r_wb_data  <= w_wb_data_d;
            r_err      <= w_err_d;
        end
    end

    // Outputs: request follows BUSY, write-enable only meaningful while requesting.
    always_comb begin
        o_dmem_req   = (r_state == StBusy);
        o_dmem_we    = (r_state == StBusy) & r_we;
        o_dmem_addr  = r_addr;
        o_dmem_wdata = r_wdata;
        o_stall      = w_stall & ~i_rst;
        o_wb_valid   = r_wb_valid;
        o_wb_rd      = r_wb_rd;
        o_wb_data    = r_wb_data;
        o_err        = r_err;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL give the maximum number of BUSY cycles to wait for dmem_ack before abandoning an access.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 ex_valid  input  1  SHALL mark a valid instruction presented from the EX/MEM register.
REQ-005 ex_mem_rd  input  1  SHALL mark a load (word).
REQ-006 ex_mem_wr  input  1  SHALL mark a store (word).
REQ-007 ex_addr  input  32  SHALL carry the ALU result: byte address for load/store, writeback value otherwise.
REQ-008 ex_wdata  input  32  SHALL carry the store data.
REQ-009 ex_rd  input  5  SHALL carry the destination register number.
REQ-010 dmem_req / dmem_we  output  1 / 1  SHALL be the memory request and write-enable.
REQ-011 dmem_addr / dmem_wdata  output  32 / 32  SHALL be the memory address and write data.
REQ-012 dmem_ack / dmem_rdata  input  1 / 32  SHALL be the memory completion pulse and read data (valid when dmem_ack=1).
REQ-013 stall  output  1  SHALL drive en_reg low on the upstream pipeline registers while high.
REQ-014 wb_valid / wb_rd / wb_data  output  1 / 5 / 32  SHALL present a registered writeback to the MEM/WB stage.
REQ-015 err  output  1  SHALL pulse one cycle on a misaligned, illegal, or timed-out access.

Function
REQ-016 The block SHALL have states IDLE and BUSY.
REQ-017 IDLE, ex_valid=1, ex_mem_rd=0, ex_mem_wr=0: next cycle wb_valid=1, wb_data=ex_addr, wb_rd=ex_rd; stall=0.
REQ-018 IDLE, ex_valid=1, exactly one of ex_mem_rd/ex_mem_wr=1, ex_addr[1:0]=00: latch addr, wdata, we=ex_mem_wr, rd; go BUSY; stall=1 combinationally in that same cycle.
REQ-019 IDLE, memory op with ex_addr[1:0]!=00, or both ex_mem_rd and ex_mem_wr=1: next cycle err=1, wb_valid=0, no request; stay IDLE; stall=0.
REQ-020 BUSY: dmem_req=1 with dmem_addr/dmem_we/dmem_wdata held stable from the latched values until completion or timeout.
REQ-021 BUSY: stall=1 except in the cycle dmem_ack=1, where stall=0 so the upstream register advances that edge.
REQ-022 BUSY, dmem_ack=1, load: next cycle wb_valid=1, wb_data=dmem_rdata, wb_rd=latched rd; go IDLE.
REQ-023 BUSY, dmem_ack=1, store: next cycle wb_valid=0; go IDLE.
REQ-024 A 4-bit-minimum wait counter SHALL clear on entering BUSY and increment each BUSY cycle without dmem_ack.
REQ-025 Counter reaching TIMEOUT with no ack: dmem_req drops next cycle, err=1 for one cycle, wb_valid=0, go IDLE, stall=0 in the timeout cycle.
REQ-026 dmem_ack in the same cycle the counter reaches TIMEOUT SHALL be honoured as completion (no err).
REQ-027 dmem_ack while IDLE SHALL be ignored.
REQ-028 wb_valid and err SHALL be single-cycle pulses; wb_data/wb_rd hold their last values when wb_valid=0.
REQ-029 ex_valid=0 in IDLE: no action, all pulses 0.

Reset
REQ-030 rst=1 SHALL force state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, err=0 at the next edge, overriding all other inputs.
REQ-031 rst asserted in BUSY SHALL abandon the access: dmem_req=0 the cycle after, no wb_valid, no err.

Verification
REQ-032 ALU op ex_addr=0x0000_1234, ex_rd=5 -> next cycle wb_valid=1, wb_data=0x0000_1234, wb_rd=5, stall never high.
REQ-033 Load ex_addr=0x100, ex_rd=8, ack after 3 cycles with rdata=0xDEAD_BEEF -> dmem_req high 3 cycles, stall high until the ack cycle, then wb_valid=1, wb_data=0xDEAD_BEEF, wb_rd=8.
REQ-034 Store ex_addr=0x200, ex_wdata=0xA5A5_A5A5, ack after 1 cycle -> dmem_we=1, dmem_wdata=0xA5A5_A5A5 stable while req high; wb_valid stays 0.
REQ-035 Load ex_addr=0x102 -> err=1 one cycle, dmem_req never high, wb_valid=0.
REQ-036 Load with no ack, TIMEOUT=15 -> err=1 after 15 BUSY cycles, dmem_req drops, stall released; a follow-on ALU op completes normally.
REQ-037 rst=1 two cycles into a BUSY load -> dmem_req=0 next cycle, no wb_valid, no err, all outputs 0.
